// File: rtl/data_sram_ctrl.sv
// Multi-cycle controller between the memory-access stage and an asynchronous data SRAM.
// Optional `DATA_SRAM_POSTED_WRITE_EN: stores retire immediately and complete in the background.
module data_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [3:0]        mem_be_n_i,
    input  logic              mem_ce_n_i,
    input  logic              mem_we_n_i,
    input  logic              mem_oe_n_i,
    input  logic              hold_i,
    output logic [31:0]       mem_rdata_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wr_hold, wr_hold_nxt;
    logic       req_wr, req_rd, req_valid;
    logic       stall_raw;
    logic       access_nxt;
    logic       unused_addr_bits;

    assign req_wr    = !mem_ce_n_i && !mem_we_n_i;
    assign req_rd    = !mem_ce_n_i &&  mem_we_n_i && !mem_oe_n_i;
    assign req_valid = req_wr || req_rd;

    // Word addressing with byte lanes from be_n: low two bits and bits above the SRAM are don't-care.
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_hold_nxt = wr_hold;
        case (state)
            ST_IDLE: begin
                cnt_nxt     = 4'd0;
                wr_hold_nxt = 1'b0;
                if (req_wr)      state_nxt = ST_WRITE;
                else if (req_rd) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (cnt == WAIT_LAST) state_nxt = ST_DONE;
                else                  cnt_nxt   = cnt + 4'd1;
            end
            ST_WRITE: begin
                // A separate hold flag keeps the counter at 4 bits even for WAIT_CYCLES=15.
                if (wr_hold) begin
                    wr_hold_nxt = 1'b0;
`ifdef DATA_SRAM_POSTED_WRITE_EN
                    state_nxt   = ST_IDLE;
`else
                    state_nxt   = ST_DONE;
`endif
                end else if (cnt == WAIT_LAST) begin
                    wr_hold_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_DONE: begin
                if (!hold_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_raw = 1'b0;
        case (state)
`ifdef DATA_SRAM_POSTED_WRITE_EN
            ST_IDLE:  stall_raw = req_rd;
            ST_WRITE: stall_raw = req_valid;
`else
            ST_IDLE:  stall_raw = req_valid;
            ST_WRITE: stall_raw = 1'b1;
`endif
            ST_READ:  stall_raw = 1'b1;
            default:  stall_raw = 1'b0;
        endcase
    end

    // Reset forces the stall low immediately even while the stage keeps presenting a request.
    assign stall_req_o = rst && stall_raw;

    assign access_nxt = (state_nxt == ST_READ) || (state_nxt == ST_WRITE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wr_hold <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_hold <= wr_hold_nxt;
        end
    end

    // SRAM pins are registered from the next-state decode so strobes align exactly with the states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'b1111;
            sram_data_oe_o <= 1'b0;
            sram_addr_o    <= '0;
            sram_data_o    <= 32'd0;
            mem_rdata_o    <= 32'd0;
        end else begin
            sram_ce_n_o    <= !access_nxt;
            sram_oe_n_o    <= !(state_nxt == ST_READ);
            sram_we_n_o    <= !((state_nxt == ST_WRITE) && (cnt_nxt != 4'd0) && !wr_hold_nxt);
            sram_data_oe_o <= (state_nxt == ST_WRITE);
            if (!access_nxt) begin
                sram_be_n_o <= 4'b1111;
            end else if (state == ST_IDLE) begin
                sram_be_n_o <= mem_be_n_i;
            end
            if (state == ST_IDLE && req_valid) begin
                sram_addr_o <= mem_addr_i[ADDR_W+1:2];
            end
            if (state == ST_IDLE && req_wr) begin
                sram_data_o <= mem_data_i;
            end
            if (state == ST_READ && cnt == WAIT_LAST) begin
                mem_rdata_o <= sram_data_i;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: load data flows through a scoreboard queue,
// SRAM pin activity is counted per access and compared against expected timing.
module tb_data_sram_ctrl;

    localparam int unsigned W      = 1;
    localparam int unsigned ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_data_i;
    logic [3:0]        mem_be_n_i;
    logic              mem_ce_n_i;
    logic              mem_we_n_i;
    logic              mem_oe_n_i;
    logic              hold_i;
    logic [31:0]       mem_rdata_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_data_o;
    logic [31:0]       sram_data_i;
    logic              sram_data_oe_o;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;
    logic [3:0]        sram_be_n_o;

    data_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_be_n_i     (mem_be_n_i),
        .mem_ce_n_i     (mem_ce_n_i),
        .mem_we_n_i     (mem_we_n_i),
        .mem_oe_n_i     (mem_oe_n_i),
        .hold_i         (hold_i),
        .mem_rdata_o    (mem_rdata_o),
        .stall_req_o    (stall_req_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata;

    int unsigned       n_stall, n_ce, n_oe, n_we, n_doe;
    logic              first_we_n, last_we_n, timed_out;
    logic [ADDR_W-1:0] seen_addr;
    logic [3:0]        seen_be;
    logic [31:0]       seen_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be_n);
        mem_ce_n_i = 1'b0;
        mem_we_n_i = !wr;
        mem_oe_n_i = wr;
        mem_addr_i = addr;
        mem_data_i = data;
        mem_be_n_i = be_n;
    endtask

    task automatic drive_idle();
        mem_ce_n_i = 1'b1;
        mem_we_n_i = 1'b1;
        mem_oe_n_i = 1'b1;
    endtask

    // Samples each cycle at the falling edge until the stall drops; returns at that falling edge.
    task automatic run_access(input int max_cycles);
        bit seen_ce = 1'b0;
        n_stall = 0; n_ce = 0; n_oe = 0; n_we = 0; n_doe = 0;
        first_we_n = 1'bx; last_we_n = 1'bx; timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!sram_ce_n_o) begin
                if (!seen_ce) first_we_n = sram_we_n_o;
                seen_ce    = 1'b1;
                last_we_n  = sram_we_n_o;
                seen_addr  = sram_addr_o;
                seen_be    = sram_be_n_o;
                seen_wdata = sram_data_o;
                n_ce++;
                if (!sram_oe_n_o)   n_oe++;
                if (!sram_we_n_o)   n_we++;
                if (sram_data_oe_o) n_doe++;
            end
            if (!stall_req_o) begin
                timed_out = 1'b0;
                break;
            end
            n_stall++;
            tick();
        end
        check("access_timeout", timed_out, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            last_rdata = exp_q.pop_front();
            check(tag, mem_rdata_o, last_rdata);
        end
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_ce_n"}, sram_ce_n_o, 1'b1);
            check({tag, "_stall"}, stall_req_o, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        hold_i = 1'b0;
        sram_data_i = 32'h0;
        mem_addr_i = 32'h0;
        mem_data_i = 32'h0;
        mem_be_n_i = 4'hF;
        drive_idle();
        last_rdata = 32'h0;

        // Reset state
        #12;
        check("rst_ce_n", sram_ce_n_o, 1'b1);
        check("rst_oe_n", sram_oe_n_o, 1'b1);
        check("rst_we_n", sram_we_n_o, 1'b1);
        check("rst_be_n", sram_be_n_o, 4'b1111);
        check("rst_doe", sram_data_oe_o, 1'b0);
        check("rst_addr", sram_addr_o, 0);
        check("rst_rdata", mem_rdata_o, 0);
        check("rst_stall", stall_req_o, 1'b0);
        tick();
        rst = 1'b1;

        // Load from 0x10, SRAM returns 0xDEADBEEF
        tick();
        drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        sram_data_i = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        run_access(40);
        check("load_stall", n_stall, W + 2);
        check("load_oe", n_oe, W + 1);
        check("load_we", n_we, 0);
        check("load_doe", n_doe, 0);
        check("load_addr", seen_addr, 32'h4);
        pop_check("load_rdata");

        // Held DONE: the same load stays presented but must not re-access the SRAM
        hold_i = 1'b1;
        sram_data_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("held_ce_n", sram_ce_n_o, 1'b1);
            check("held_stall", stall_req_o, 1'b0);
            check("held_rdata", mem_rdata_o, last_rdata);
        end
        hold_i = 1'b0;
        drive_idle();
        tick();
        quiet_cycles("after_hold", 2);

        // Reset mid-READ
        tick();
        drive_req(1'b0, 32'h0000_0020, 32'h0, 4'b0000);
        sram_data_i = 32'h55AA_55AA;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ce_n", sram_ce_n_o, 1'b1);
        check("midrst_oe_n", sram_oe_n_o, 1'b1);
        check("midrst_we_n", sram_we_n_o, 1'b1);
        check("midrst_stall", stall_req_o, 1'b0);
        check("midrst_rdata", mem_rdata_o, 0);
        check("midrst_addr", sram_addr_o, 0);
        last_rdata = 32'h0;
        drive_idle();
        tick();
        rst = 1'b1;
        quiet_cycles("after_rst", 3);
        check("after_rst_rdata", mem_rdata_o, last_rdata);

        // Invalid request: ce low with both strobes high
        tick();
        mem_ce_n_i = 1'b0;
        mem_we_n_i = 1'b1;
        mem_oe_n_i = 1'b1;
        run_access(5);
        check("inv_stall", n_stall, 0);
        check("inv_ce", n_ce, 0);
        tick();
        quiet_cycles("inv", 2);
        drive_idle();

`ifdef DATA_SRAM_POSTED_WRITE_EN
        // Posted store followed immediately by a load
        tick();
        drive_req(1'b1, 32'h0000_0007, 32'hAAAA_AAAA, 4'b0111);
        @(negedge clk);
        check("posted_store_stall", stall_req_o, 1'b0);
        tick();
        drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        sram_data_i = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        run_access(40);
        check("posted_load_stall", n_stall, 2 * W + 4);
        check("posted_ce", n_ce, 2 * W + 3);
        check("posted_we", n_we, W);
        check("posted_oe", n_oe, W + 1);
        pop_check("posted_rdata");
        tick();
        drive_idle();
`else
        // Back-to-back: aliased load then a byte store on the next instruction
        tick();
        drive_req(1'b0, 32'hFFF0_0013, 32'h0, 4'b0000);
        sram_data_i = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        run_access(40);
        check("alias_stall", n_stall, W + 2);
        check("alias_addr", seen_addr, (32'hFFF0_0013 >> 2) & ((32'h1 << ADDR_W) - 1));
        pop_check("alias_rdata");
        tick();
        drive_req(1'b1, 32'h0000_0007, 32'hAAAA_AAAA, 4'b0111);
        sram_data_i = 32'h1111_2222;
        run_access(40);
        check("store_stall", n_stall, W + 3);
        check("store_ce", n_ce, W + 2);
        check("store_we", n_we, W);
        check("store_setup_we_n", first_we_n, 1'b1);
        check("store_hold_we_n", last_we_n, 1'b1);
        check("store_doe", n_doe, W + 2);
        check("store_be", seen_be, 4'b0111);
        check("store_addr", seen_addr, 32'h1);
        check("store_wdata", seen_wdata, 32'hAAAA_AAAA);
        check("store_rdata_kept", mem_rdata_o, last_rdata);
        tick();
        drive_idle();
        quiet_cycles("after_store", 2);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Multi-cycle controller between the memory-access stage and the off-chip asynchronous data SRAM. It consumes the stage's active-low request strobes, address, write data and byte enables. It sequences SRAM read/write timing with a programmable wait-state count, returns load data to the stage, and raises a stall request so the pipeline holds the load/store instruction until the access completes.

## Interface
- WAIT_CYCLES, 1: SRAM wait states per access, range 1..15.
- ADDR_W, 20: SRAM word-address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- mem_addr_i  in  32  byte address from the memory stage.
- mem_data_i  in  32  store data from the memory stage.
- mem_be_n_i  in  4  byte enables, active-low.
- mem_ce_n_i / mem_we_n_i / mem_oe_n_i  in  1 each  request strobes, active-low.
- hold_i  in  1  external stall; the memory stage will present the same instruction next cycle.
- mem_rdata_o  out  32  load data, returned to the stage's memory-data input.
- stall_req_o  out  1  pipeline stall request.
- sram_addr_o  out  ADDR_W  word address.
- sram_data_o  out  32  SRAM write data.
- sram_data_i  in  32  SRAM read data.
- sram_data_oe_o  out  1  drive enable for the top-level data tristate.
- sram_ce_n_o / sram_oe_n_o / sram_we_n_o  out  1 each  SRAM strobes, active-low.
- sram_be_n_o  out  4  SRAM byte enables, active-low.

## Operation
- **States:** IDLE, READ, WRITE, DONE. A 4-bit counter `cnt` counts cycles within READ and WRITE.
- **Request decode:** a request exists when mem_ce_n_i=0.
  - write if mem_we_n_i=0; write wins if mem_oe_n_i is also 0.
  - read if mem_oe_n_i=0 and mem_we_n_i=1.
  - ce low with both strobes high: ignored, no stall.
- **IDLE with a request:**
  - latch sram_addr_o = mem_addr_i[ADDR_W+1:2], sram_be_n_o, and sram_data_o (writes only);
  - clear cnt and enter READ or WRITE;
  - stall_req_o is high combinationally in that same cycle.
- **READ:**
  - sram_ce_n_o=0, sram_oe_n_o=0, data_oe=0;
  - lasts WAIT_CYCLES+1 cycles;
  - on the last cycle, sram_data_i is registered into mem_rdata_o;
  - then enter DONE.
- **WRITE:** sram_ce_n_o=0, data_oe=1; lasts WAIT_CYCLES+2 cycles.
  - setup cycle (cnt=0): we_n=1;
  - pulse cycles (cnt=1..WAIT_CYCLES): we_n=0;
  - hold cycle: we_n=1, address and data unchanged;
  - then enter DONE.
- **DONE:**
  - stall_req_o=0, all SRAM strobes inactive, mem_rdata_o stable;
  - next state IDLE if hold_i=0; stay in DONE while hold_i=1, so a held instruction never re-triggers its access.
- **stall_req_o** = (IDLE and a valid request) or READ or WRITE.
- mem_rdata_o changes only at read capture. It holds its value across writes and idle periods.
- **Address aliasing:** mem_addr_i[1:0] are not used for addressing; byte lane selection comes only from be_n. Address bits above ADDR_W+1 are ignored.

## Timing
- **Reset** (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE, cnt=0;
  - sram_ce_n_o=sram_oe_n_o=sram_we_n_o=1, sram_be_n_o=4'b1111;
  - sram_addr_o=0, sram_data_o=0, sram_data_oe_o=0;
  - mem_rdata_o=0, stall_req_o=0.
- **Load:** stall high for WAIT_CYCLES+2 cycles (IDLE cycle plus READ), then DONE with data valid. WAIT_CYCLES=1 gives 3 stalled cycles.
- **Store:** stall high for WAIT_CYCLES+3 cycles. WAIT_CYCLES=1 gives 4.
- **SRAM outputs** are registered, with no combinational path from mem_* inputs to sram_* outputs.
- **Back-to-back accesses:** DONE→IDLE costs one cycle, so the next request starts one cycle after DONE.
- **Request changes:** request inputs that change during READ or WRITE are ignored, because the access was latched on entry.

## Configuration
- `DATA_SRAM_POSTED_WRITE_EN`
  - **Defined:** a write accepted in IDLE does not assert stall_req_o, and the pipeline advances immediately. WRITE executes in the background and returns directly to IDLE, skipping DONE. Any new request arriving during that WRITE sees stall_req_o=1 until the controller is back in IDLE.
  - **Undefined:** stores stall for the full duration as described under Timing.

## Test plan
- **Reset mid-access:** assert rst=0 mid-READ -> same cycle: all strobes 1, stall_req_o=0, state IDLE; after release, no residual access.
- **Load:** WAIT_CYCLES=1, load from addr 0x0000_0010 with SRAM returning 0xDEADBEEF -> sram_addr_o=0x4; oe_n low 2 cycles; stall high 3 cycles; DONE shows mem_rdata_o=0xDEADBEEF.
- **Byte store:** addr 0x0000_0007, be_n=4'b0111, data 0xAAAAAAAA -> we_n low exactly 1 cycle with setup and hold cycles around it; sram_be_n_o=4'b0111; sram_addr_o=0x1; stall high 4 cycles.
- **Held DONE:** hold_i=1 for 3 cycles while in DONE -> stays in DONE; no second SRAM access; mem_rdata_o stable.
- **Back-to-back and invalid requests:** load then store on consecutive instructions -> one idle cycle between accesses; ce_n=0 with we_n=oe_n=1 -> no stall and no SRAM activity.
- **Posted write:** with `DATA_SRAM_POSTED_WRITE_EN`, a store followed immediately by a load -> stall low for the store; load stalls until the write's hold cycle ends, then proceeds normally.
